mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Main control FSM for the multicycle 32-bit MIPS datapath. Sequences each instruction through
//  fetch/decode/execute/memory/writeback and drives the datapath mux selects and write enables.
//  Produces the 2-bit ALUOp consumed by the ALU control decoder (00 add, 01 sub, 10 funct-decoded).
//  Stalls on a memory-ready handshake for instruction and data accesses.
// PARAMETERS
//  OPW  6  opcode field width (instr[31:26])
// PORTS
//  clk          in   1  single system clock, rising edge
//  reset        in   1  synchronous, active-high reset
//  opcode       in   6  instr[31:26] from instruction register, valid from DECODE onward
//  mem_ready    in   1  memory completes the current access this cycle
//  mem_req      out  1  memory access request (held until mem_ready)
//  IorD         out  1  0=PC addresses memory, 1=ALUOut addresses memory
//  MemWrite     out  1  data memory write strobe
//  IRWrite      out  1  load instruction register
//  MemtoReg     out  1  0=ALUOut, 1=MDR to register write data
//  RegDst       out  1  0=rt, 1=rd as destination register
//  RegWrite     out  1  register file write enable
//  ALUSrcA      out  1  0=PC, 1=register A
//  ALUSrcB      out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  ALUOp        out  2  00 add, 01 subtract, 10 use funct field
//  PCSrc        out  2  00=ALU result, 01=ALUOut, 10=jump target
//  PCWrite      out  1  unconditional PC write
//  PCWriteCond  out  1  PC write qualified by ALU zero (beq)
//  illegal_op   out  1  one-cycle pulse: unsupported opcode detected in DECODE
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Reset forces state=IDLE next edge.
//  - Outputs are Moore: pure function of state. In IDLE every output is 0 (reset value of all).
//  - IDLE -> FETCH unconditionally after one cycle.
//  - FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
//    IRWrite=PCWrite=mem_ready (enables asserted only in the completing cycle).
//    Stay while mem_ready=0; -> DECODE when mem_ready=1.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next by opcode:
//    100011 lw / 101011 sw -> MEMADR; 000000 R -> EXECUTE; 000100 beq -> BRANCH;
//    001000 addi -> ADDIEX; 000010 j -> JUMP; other -> FETCH with illegal_op=1 (Mealy pulse).
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw -> MEMRD, sw -> MEMWR.
//  - MEMRD: mem_req=1, IorD=1; hold until mem_ready, then -> MEMWB.
//  - MEMWR: mem_req=1, IorD=1, MemWrite=mem_ready; hold until mem_ready, then -> FETCH.
//  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
//  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB. ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWriteCond=1 -> FETCH.
//  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
//  - JUMP: PCSrc=10, PCWrite=1 -> FETCH.
//  - Latency: R/addi/lw-hit 4/4/5 cycles with zero-wait memory; sw/beq/j 4/3/3.
//  - Opcode sampled only in DECODE and MEMADR; X/other opcodes never leave FSM in unknown state.
//  - Reset mid-operation (any state, incl. stalled MEMWR): next state IDLE, no write strobe
//    is asserted in the cycle following reset; a pending memory request is dropped.
//  - Unused select outputs are driven 0 (never X) in states that do not use them.
// STRUCTURE
//  - Package mips_ctrl_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J),
//    state enum (4-bit), ALUOp constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT), ALUSrcB/PCSrc codes.
//  - Sub-module mips_ctrl_decode: combinational state(+mem_ready) -> control word; top holds
//    only the state register and next-state logic.
// TESTING
//  - reset=1 for 2 cycles in arbitrary state -> all outputs 0, state IDLE; release -> FETCH next cycle.
//  - R-type (opcode 000000), mem_ready=1 -> FETCH,DECODE,EXECUTE(ALUOp=10),ALUWB(RegDst=1,RegWrite=1), FETCH.
//  - lw (100011), mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles, MEMWB MemtoReg=1,RegWrite=1.
//  - beq (000100) -> BRANCH with ALUOp=01, PCSrc=01, PCWriteCond=1, PCWrite=0; back to FETCH.
//  - opcode 111111 in DECODE -> illegal_op=1 for exactly 1 cycle, next state FETCH, no RegWrite.
//  - sw (101011) stalled in MEMWR, reset asserted -> MemWrite never pulses, IDLE then FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, states,
// ALU/mux select codes and the packed control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWR   = 4'd5,
        S_MEMWB   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       pc_write_cond;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// State (+mem_ready for the completing-cycle strobes) to datapath control word.
// Purely combinational; every field defaults to 0 so unused selects are never X.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                // IR and PC only update in the cycle the fetch actually completes
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.mem_write = mem_ready;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_src        = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register and next-state logic;
// the control word comes from mips_ctrl_decode. Memory states stall until mem_ready.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           IorD,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic [1:0]     PCSrc,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           illegal_op
);

    state_t state_q, state_d;
    logic   illegal_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Unknown opcodes fall to the default arms, so state_d is always a legal state.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                case (opcode)
                    OP_LW:   state_d = S_MEMRD;
                    OP_SW:   state_d = S_MEMWR;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_MEMWB:   state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    mips_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign mem_req     = ctrl.mem_req;
    assign IorD        = ctrl.iord;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSrc       = ctrl.pc_src;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign illegal_op  = illegal_d;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed-vector bench: the driver pushes hand-computed control words into a queue,
// a monitor on the falling edge pops and compares against the DUT outputs.
module tb_mips_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, IorD, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCWrite, PCWriteCond, illegal_op;

    // {mem_req,IorD,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,PCWrite,PCWriteCond,illegal_op}
    localparam logic [16:0] E_IDLE       = 17'b0;
    localparam logic [16:0] E_FETCH_W    = {8'b1000_0000, 2'b01, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_FETCH_R    = {8'b1001_0000, 2'b01, 2'b00, 2'b00, 3'b100};
    localparam logic [16:0] E_DECODE     = {8'b0000_0000, 2'b11, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_DECODE_ILL = {8'b0000_0000, 2'b11, 2'b00, 2'b00, 3'b001};
    localparam logic [16:0] E_MEMADR     = {8'b0000_0001, 2'b10, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_MEMRD      = {8'b1100_0000, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_MEMWR_W    = {8'b1100_0000, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_MEMWR_R    = {8'b1110_0000, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_MEMWB      = {8'b0000_1010, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_EXEC       = {8'b0000_0001, 2'b00, 2'b10, 2'b00, 3'b000};
    localparam logic [16:0] E_ALUWB      = {8'b0000_0110, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_BRANCH     = {8'b0000_0001, 2'b00, 2'b01, 2'b01, 3'b010};
    localparam logic [16:0] E_ADDIWB     = {8'b0000_0010, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_JUMP       = {8'b0000_0000, 2'b00, 2'b00, 2'b10, 3'b100};

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_BAD  = 6'b111111;

    logic [16:0] exp_q[$];
    string       name_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [16:0] act;

    mips_multicycle_control #(.OPW(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .IorD        (IorD),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSrc       (PCSrc),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act = {mem_req, IorD, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSrc, PCWrite, PCWriteCond, illegal_op};

    // Drive one cycle's inputs just after the edge and queue the outputs expected in that cycle.
    task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                        input string nm, input logic [16:0] exp_v);
        reset     = rst;
        opcode    = op;
        mem_ready = mr;
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic [16:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_vec++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b", nm, act, e);
                end
            end
        end
    end

    initial begin : driver
        reset = 1'b1; opcode = OPC_R; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(1, OPC_R, 1, "reset_idle", E_IDLE);
        step(0, OPC_R, 1, "release_idle", E_IDLE);
        // R-type, zero-wait memory
        step(0, OPC_R, 1, "r_fetch", E_FETCH_R);
        step(0, OPC_R, 1, "r_decode", E_DECODE);
        step(0, OPC_R, 1, "r_execute", E_EXEC);
        step(0, OPC_R, 1, "r_aluwb", E_ALUWB);
        // lw with a fetch stall and two data-wait cycles
        step(0, OPC_LW, 0, "lw_fetch_wait", E_FETCH_W);
        step(0, OPC_LW, 1, "lw_fetch", E_FETCH_R);
        step(0, OPC_LW, 1, "lw_decode", E_DECODE);
        step(0, OPC_LW, 1, "lw_memadr", E_MEMADR);
        step(0, OPC_LW, 0, "lw_memrd_w1", E_MEMRD);
        step(0, OPC_LW, 0, "lw_memrd_w2", E_MEMRD);
        step(0, OPC_LW, 1, "lw_memrd_rdy", E_MEMRD);
        step(0, OPC_LW, 1, "lw_memwb", E_MEMWB);
        // beq
        step(0, OPC_BEQ, 1, "beq_fetch", E_FETCH_R);
        step(0, OPC_BEQ, 1, "beq_decode", E_DECODE);
        step(0, OPC_BEQ, 1, "beq_branch", E_BRANCH);
        // illegal opcode: pulse for one cycle, straight back to fetch
        step(0, OPC_BAD, 1, "ill_fetch", E_FETCH_R);
        step(0, OPC_BAD, 1, "ill_decode", E_DECODE_ILL);
        step(0, OPC_BAD, 0, "ill_refetch", E_FETCH_W);
        step(0, OPC_ADDI, 1, "addi_fetch", E_FETCH_R);
        step(0, OPC_ADDI, 1, "addi_decode", E_DECODE);
        step(0, OPC_ADDI, 1, "addi_ex", E_MEMADR);
        step(0, OPC_ADDI, 1, "addi_wb", E_ADDIWB);
        // j
        step(0, OPC_J, 1, "j_fetch", E_FETCH_R);
        step(0, OPC_J, 1, "j_decode", E_DECODE);
        step(0, OPC_J, 1, "j_jump", E_JUMP);
        // sw completing normally
        step(0, OPC_SW, 1, "sw_fetch", E_FETCH_R);
        step(0, OPC_SW, 1, "sw_decode", E_DECODE);
        step(0, OPC_SW, 1, "sw_memadr", E_MEMADR);
        step(0, OPC_SW, 1, "sw_memwr_rdy", E_MEMWR_R);
        // sw stalled in MEMWR, then reset: no MemWrite, IDLE, then FETCH
        step(0, OPC_SW, 1, "sw2_fetch", E_FETCH_R);
        step(0, OPC_SW, 1, "sw2_decode", E_DECODE);
        step(0, OPC_SW, 1, "sw2_memadr", E_MEMADR);
        step(0, OPC_SW, 0, "sw2_memwr_wait", E_MEMWR_W);
        step(1, OPC_SW, 0, "sw2_memwr_rst", E_MEMWR_W);
        step(1, OPC_SW, 1, "sw2_rst_idle", E_IDLE);
        step(0, OPC_SW, 1, "sw2_release_idle", E_IDLE);
        step(0, OPC_SW, 0, "sw2_refetch", E_FETCH_W);
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
